// File: rtl/ervp_orca_cache_line_refill_pkg.sv
// ============================================================================
// Module   : ervp_orca_cache_line_refill_pkg
// Brief    : Shared types and helpers for the ORCA cache line refill engine:
//            FSM state encoding, ceiling divide and clog2-with-minimum-1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ervp_orca_cache_line_refill_pkg;

  // Refill engine states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WB_FETCH = 3'd1,
    ST_WB_SEND  = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_DATA  = 3'd4,
    ST_DONE     = 3'd5
  } refill_state_e;

  // Ceiling division used to size the burst from line and word size
  function automatic int divideru(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Index width; never below one bit so single-beat lines still have a port
  function automatic int clog2_min1(input int val);
    int r;
    r = $clog2(val);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ervp_orca_cache_beat_counter.sv
// ============================================================================
// Module   : ervp_orca_cache_beat_counter
// Brief    : Beat index counter for line bursts; clear has priority over
//            increment, wraps to zero after the last beat, flags last beat.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ervp_orca_cache_beat_counter #(
  parameter int NUM_TRANSFER = 4,
  parameter int BW_IDX       = 2
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              clear,
  input  logic              inc,
  output logic [BW_IDX-1:0] cnt,
  output logic              last
);

  localparam logic [BW_IDX-1:0] LAST_IDX = BW_IDX'(NUM_TRANSFER - 1);

  logic [BW_IDX-1:0] cnt_q;
  logic [BW_IDX-1:0] cnt_d;

  assign last = (cnt_q == LAST_IDX);
  assign cnt  = cnt_q;

  // Next count: clear wins, otherwise step and wrap after the last beat
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : (cnt_q + BW_IDX'(1));
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ervp_orca_cache_line_refill.sv
// ============================================================================
// Module   : ervp_orca_cache_line_refill
// Brief    : Cache-miss line engine. Optionally writes back a dirty victim
//            as one OIMM write burst, then fetches the new line as one OIMM
//            read burst, writing each returned word into the data RAM.
//            Optional macro ORCA_CACHE_REFILL_STATS_EN adds refill and
//            write-back event counters (stat_refill_cnt, stat_wb_cnt).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ervp_orca_cache_line_refill
  import ervp_orca_cache_line_refill_pkg::*;
#(
  parameter int BW_ADDR         = 32,
  parameter int BW_DATA         = 32,
  parameter int BW_BURST_LENGTH = 4,
  parameter int CACHE_LINE_SIZE = 16,
  localparam int NUM_BYTE_IN_DATA = BW_DATA / 8,
  localparam int NUM_TRANSFER     = divideru(CACHE_LINE_SIZE, NUM_BYTE_IN_DATA),
  localparam int BW_IDX           = clog2_min1(NUM_TRANSFER)
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [BW_ADDR-1:0]          req_fill_addr,
  input  logic                        req_wb,
  input  logic [BW_ADDR-1:0]          req_wb_addr,
  output logic                        vic_rd_en,
  output logic [BW_IDX-1:0]           vic_rd_idx,
  input  logic [BW_DATA-1:0]          vic_rd_data,
  output logic                        fill_we,
  output logic [BW_IDX-1:0]           fill_idx,
  output logic [BW_DATA-1:0]          fill_data,
  output logic                        done,
  output logic                        busy,
  output logic [BW_ADDR-1:0]          m_oimm_address,
  output logic [BW_BURST_LENGTH-1:0]  m_oimm_burstlength_minus1,
  output logic [NUM_BYTE_IN_DATA-1:0] m_oimm_byteenable,
  output logic                        m_oimm_requestvalid,
  output logic                        m_oimm_readnotwrite,
  output logic [BW_DATA-1:0]          m_oimm_writedata,
  output logic                        m_oimm_writelast,
  input  logic [BW_DATA-1:0]          m_oimm_readdata,
  input  logic                        m_oimm_readdatavalid,
  input  logic                        m_oimm_waitrequest
`ifdef ORCA_CACHE_REFILL_STATS_EN
  ,
  output logic [31:0]                 stat_refill_cnt,
  output logic [31:0]                 stat_wb_cnt
`endif
);

  // Byte offset bits inside a line are forced to zero on both addresses
  localparam int                 LINE_OFS  = $clog2(CACHE_LINE_SIZE);
  localparam logic [BW_ADDR-1:0] LINE_MASK = ~((BW_ADDR'(1) << LINE_OFS) - BW_ADDR'(1));

  refill_state_e      state_q, state_d;
  logic [BW_ADDR-1:0] fill_addr_q, fill_addr_d;
  logic [BW_ADDR-1:0] wb_addr_q, wb_addr_d;
  logic [BW_DATA-1:0] beat_q, beat_d;
  logic               first_q, first_d;

  logic               cnt_clear;
  logic               cnt_inc;
  logic [BW_IDX-1:0]  cnt;
  logic               cnt_last;

  ervp_orca_cache_beat_counter #(
    .NUM_TRANSFER (NUM_TRANSFER),
    .BW_IDX       (BW_IDX)
  ) u_beat_counter (
    .clk   (clk),
    .rstnn (rstnn),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  // Next-state and request/strobe decode; everything defaults inactive
  always_comb begin
    state_d             = state_q;
    fill_addr_d         = fill_addr_q;
    wb_addr_d           = wb_addr_q;
    beat_d              = beat_q;
    first_d             = 1'b0;
    cnt_clear           = 1'b0;
    cnt_inc             = 1'b0;
    req_ready           = 1'b0;
    vic_rd_en           = 1'b0;
    fill_we             = 1'b0;
    done                = 1'b0;
    m_oimm_requestvalid = 1'b0;
    m_oimm_readnotwrite = 1'b0;
    m_oimm_address      = '0;
    m_oimm_writelast    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          fill_addr_d = req_fill_addr & LINE_MASK;
          wb_addr_d   = req_wb_addr & LINE_MASK;
          cnt_clear   = 1'b1;
          state_d     = req_wb ? ST_WB_FETCH : ST_RD_REQ;
        end
      end
      ST_WB_FETCH: begin
        vic_rd_en = 1'b1;
        first_d   = 1'b1;
        state_d   = ST_WB_SEND;
      end
      ST_WB_SEND: begin
        m_oimm_requestvalid = 1'b1;
        m_oimm_address      = wb_addr_q;
        m_oimm_writelast    = cnt_last;
        // RAM word arrives during the first send cycle; hold it for stalls
        if (first_q) begin
          beat_d = vic_rd_data;
        end
        if (!m_oimm_waitrequest) begin
          if (cnt_last) begin
            cnt_clear = 1'b1;
            state_d   = ST_RD_REQ;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_WB_FETCH;
          end
        end
      end
      ST_RD_REQ: begin
        m_oimm_requestvalid = 1'b1;
        m_oimm_readnotwrite = 1'b1;
        m_oimm_address      = fill_addr_q;
        if (!m_oimm_waitrequest) begin
          cnt_clear = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_oimm_readdatavalid) begin
          fill_we = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy                      = (state_q != ST_IDLE);
  assign vic_rd_idx                = vic_rd_en ? cnt : '0;
  assign fill_idx                  = fill_we ? cnt : '0;
  assign fill_data                 = fill_we ? m_oimm_readdata : '0;
  assign m_oimm_writedata          = (state_q != ST_WB_SEND) ? '0 :
                                     (first_q ? vic_rd_data : beat_q);
  assign m_oimm_burstlength_minus1 = BW_BURST_LENGTH'(NUM_TRANSFER - 1);
  assign m_oimm_byteenable         = '1;

  // State, address and beat registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= ST_IDLE;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      beat_q      <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      wb_addr_q   <= wb_addr_d;
      beat_q      <= beat_d;
      first_q     <= first_d;
    end
  end

`ifdef ORCA_CACHE_REFILL_STATS_EN
  logic [31:0] stat_refill_q, stat_refill_d;
  logic [31:0] stat_wb_q, stat_wb_d;
  logic        wb_last_accept;

  // Count installed lines and completed write-back bursts, wrapping freely
  always_comb begin
    wb_last_accept = (state_q == ST_WB_SEND) && cnt_last && !m_oimm_waitrequest;
    stat_refill_d  = done ? (stat_refill_q + 32'd1) : stat_refill_q;
    stat_wb_d      = wb_last_accept ? (stat_wb_q + 32'd1) : stat_wb_q;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      stat_refill_q <= '0;
      stat_wb_q     <= '0;
    end else begin
      stat_refill_q <= stat_refill_d;
      stat_wb_q     <= stat_wb_d;
    end
  end

  assign stat_refill_cnt = stat_refill_q;
  assign stat_wb_cnt     = stat_wb_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ervp_orca_cache_line_refill.sv
// ============================================================================
// Module   : tb_ervp_orca_cache_line_refill
// Brief    : Directed bench for the cache line refill engine: cycle table for
//            a clean miss with stalls, gaps and spurious beats, plus dirty
//            miss, write stall, mid-burst reset and statistics sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ervp_orca_cache_line_refill;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_fill_addr = '0;
  logic        req_wb = 1'b0;
  logic [31:0] req_wb_addr = '0;
  logic        vic_rd_en;
  logic [1:0]  vic_rd_idx;
  logic [31:0] vic_rd_data;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        done;
  logic        busy;
  logic [31:0] m_oimm_address;
  logic [3:0]  m_oimm_burstlength_minus1;
  logic [3:0]  m_oimm_byteenable;
  logic        m_oimm_requestvalid;
  logic        m_oimm_readnotwrite;
  logic [31:0] m_oimm_writedata;
  logic        m_oimm_writelast;
  logic [31:0] m_oimm_readdata = '0;
  logic        m_oimm_readdatavalid = 1'b0;
  logic        m_oimm_waitrequest = 1'b0;
`ifdef ORCA_CACHE_REFILL_STATS_EN
  logic [31:0] stat_refill_cnt;
  logic [31:0] stat_wb_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] vic_mem [NT];

  always #5 clk = ~clk;

  ervp_orca_cache_line_refill dut (
    .clk                       (clk),
    .rstnn                     (rstnn),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_fill_addr             (req_fill_addr),
    .req_wb                    (req_wb),
    .req_wb_addr               (req_wb_addr),
    .vic_rd_en                 (vic_rd_en),
    .vic_rd_idx                (vic_rd_idx),
    .vic_rd_data               (vic_rd_data),
    .fill_we                   (fill_we),
    .fill_idx                  (fill_idx),
    .fill_data                 (fill_data),
    .done                      (done),
    .busy                      (busy),
    .m_oimm_address            (m_oimm_address),
    .m_oimm_burstlength_minus1 (m_oimm_burstlength_minus1),
    .m_oimm_byteenable         (m_oimm_byteenable),
    .m_oimm_requestvalid       (m_oimm_requestvalid),
    .m_oimm_readnotwrite       (m_oimm_readnotwrite),
    .m_oimm_writedata          (m_oimm_writedata),
    .m_oimm_writelast          (m_oimm_writelast),
    .m_oimm_readdata           (m_oimm_readdata),
    .m_oimm_readdatavalid      (m_oimm_readdatavalid),
`ifdef ORCA_CACHE_REFILL_STATS_EN
    .stat_refill_cnt           (stat_refill_cnt),
    .stat_wb_cnt               (stat_wb_cnt),
`endif
    .m_oimm_waitrequest        (m_oimm_waitrequest)
  );

  // Victim data RAM: registered read, word valid the cycle after the strobe
  always @(posedge clk or negedge rstnn) begin
    if (!rstnn) vic_rd_data <= '0;
    else if (vic_rd_en) vic_rd_data <= vic_mem[vic_rd_idx];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic        wb;
    logic [31:0] faddr;
    logic        wr;
    logic        rdv;
    logic [31:0] rdata;
    logic [71:0] exp;
  } vec_t;

  function automatic vec_t v(input logic rv, input logic [31:0] faddr, input logic wr,
                             input logic rdv, input logic [31:0] rdata,
                             input logic e_ready, input logic e_busy, input logic e_rv,
                             input logic e_rnw, input logic [31:0] e_addr, input logic e_we,
                             input logic [1:0] e_idx, input logic [31:0] e_fd, input logic e_done);
    vec_t r;
    r.rv = rv; r.wb = 1'b0; r.faddr = faddr; r.wr = wr; r.rdv = rdv; r.rdata = rdata;
    r.exp = {e_ready, e_busy, e_rv, e_rnw, e_addr, e_we, e_idx, e_fd, e_done};
    return r;
  endfunction

  // Read request, NT returned words with optional gaps, done pulse, back to idle
  task automatic read_phase(input logic [31:0] fa, input logic [31:0] base, input int gap);
    m_oimm_waitrequest = 1'b0;
    #1;
    check("rd_req", {m_oimm_requestvalid, m_oimm_readnotwrite, m_oimm_address}, {1'b1, 1'b1, fa});
    check("rd_len_be", {m_oimm_burstlength_minus1, m_oimm_byteenable}, 8'h3F);
    for (int k = 0; k < NT; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1; m_oimm_readdatavalid = 1'b0; #1;
        check("rd_gap", {fill_we, done, busy}, 3'b001);
      end
      @(posedge clk); #1;
      m_oimm_readdatavalid = 1'b1;
      m_oimm_readdata = base + 32'(k);
      #1;
      check("rd_fill", {fill_we, fill_idx, fill_data}, {1'b1, 2'(k), base + 32'(k)});
    end
    @(posedge clk); #1; m_oimm_readdatavalid = 1'b0; #1;
    check("rd_done", {done, busy, fill_we}, 3'b110);
    @(posedge clk); #2;
    check("rd_idle", {done, busy, req_ready}, 3'b001);
  endtask

  task automatic run_clean(input logic [31:0] fa, input logic [31:0] fa_exp, input logic [31:0] base);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = fa; #1;
    check("clean_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    read_phase(fa_exp, base, 0);
  endtask

  task automatic run_dirty(input logic [31:0] wba, input logic [31:0] fa, input logic [31:0] pat,
                           input int stall_beat, input int stall_len);
    int writes = 0;
    int stall_left = stall_len;
    int cyc = 0;
    bit in_rd = 0;
    bit held_v = 0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    for (int i = 0; i < NT; i++) vic_mem[i] = pat + 32'(i * 16'h0101);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wb = 1'b1; req_wb_addr = wba; req_fill_addr = fa; #1;
    check("dirty_accept", req_ready, 1'b1);
    while (!in_rd && cyc < 100) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc++;
      if (m_oimm_requestvalid && m_oimm_readnotwrite) begin
        in_rd = 1;
      end else begin
        m_oimm_waitrequest = m_oimm_requestvalid && (writes == stall_beat) && (stall_left > 0);
        if (m_oimm_waitrequest) stall_left--;
        #1;
        if (!m_oimm_requestvalid) begin
          check("wb_fetch", {vic_rd_en, vic_rd_idx}, {1'b1, 2'(writes)});
        end else begin
          if (held_v) check("wb_hold", {m_oimm_writedata, m_oimm_writelast}, {held_d, held_l});
          if (m_oimm_waitrequest) begin
            held_v = 1; held_d = m_oimm_writedata; held_l = m_oimm_writelast;
          end else begin
            held_v = 0;
            if (writes < NT)
              check("wb_beat", {m_oimm_readnotwrite, m_oimm_address, m_oimm_writedata, m_oimm_writelast},
                    {1'b0, wba, vic_mem[writes], writes == NT - 1});
            writes++;
          end
        end
      end
    end
    m_oimm_waitrequest = 1'b0;
    check("wb_beats", {in_rd, 32'(writes)}, {1'b1, 32'(NT)});
    if (in_rd) read_phase(fa, pat ^ 32'h5555_0000, 0);
  endtask

  vec_t tbl [16];

  initial begin
    // Clean miss with request stall, 3-cycle gap, busy request and spurious beats
    tbl[0]  = v(1, 32'h0000_1004, 0, 0, 0,   1, 0, 0, 0, 0,            0, 0, 0,   0);
    tbl[1]  = v(0, 0,             1, 0, 0,   0, 1, 1, 1, 32'h1000,     0, 0, 0,   0);
    tbl[2]  = v(0, 0,             1, 0, 0,   0, 1, 1, 1, 32'h1000,     0, 0, 0,   0);
    tbl[3]  = v(0, 0,             0, 0, 0,   0, 1, 1, 1, 32'h1000,     0, 0, 0,   0);
    tbl[4]  = v(0, 0,             0, 0, 0,   0, 1, 0, 0, 0,            0, 0, 0,   0);
    tbl[5]  = v(0, 0,             0, 1, 32'hA0, 0, 1, 0, 0, 0,         1, 0, 32'hA0, 0);
    tbl[6]  = v(0, 0,             0, 0, 32'hEE, 0, 1, 0, 0, 0,         0, 0, 0,   0);
    tbl[7]  = v(0, 0,             0, 0, 32'hEE, 0, 1, 0, 0, 0,         0, 0, 0,   0);
    tbl[8]  = v(0, 0,             0, 0, 32'hEE, 0, 1, 0, 0, 0,         0, 0, 0,   0);
    tbl[9]  = v(0, 0,             0, 1, 32'hA1, 0, 1, 0, 0, 0,         1, 1, 32'hA1, 0);
    tbl[10] = v(0, 0,             0, 1, 32'hA2, 0, 1, 0, 0, 0,         1, 2, 32'hA2, 0);
    tbl[11] = v(1, 32'h0000_9000, 0, 0, 0,   0, 1, 0, 0, 0,            0, 0, 0,   0);
    tbl[12] = v(0, 0,             0, 1, 32'hA3, 0, 1, 0, 0, 0,         1, 3, 32'hA3, 0);
    tbl[13] = v(0, 0,             0, 1, 32'hB0, 0, 1, 0, 0, 0,         0, 0, 0,   1);
    tbl[14] = v(0, 0,             0, 1, 32'hB1, 1, 0, 0, 0, 0,         0, 0, 0,   0);
    tbl[15] = v(0, 0,             0, 0, 0,   1, 0, 0, 0, 0,            0, 0, 0,   0);

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs",
          {req_ready, busy, vic_rd_en, fill_we, done, m_oimm_requestvalid, m_oimm_readnotwrite,
           m_oimm_writelast, m_oimm_address, m_oimm_writedata, fill_data},
          {1'b1, 7'b0, 96'b0});
    check("reset_consts", {m_oimm_burstlength_minus1, m_oimm_byteenable}, 8'h3F);
    rstnn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      req_valid = tbl[i].rv; req_wb = tbl[i].wb; req_fill_addr = tbl[i].faddr;
      m_oimm_waitrequest = tbl[i].wr; m_oimm_readdatavalid = tbl[i].rdv;
      m_oimm_readdata = tbl[i].rdata;
      #1;
      check($sformatf("vec%0d", i),
            {req_ready, busy, m_oimm_requestvalid, m_oimm_readnotwrite, m_oimm_address,
             fill_we, fill_idx, fill_data, done},
            tbl[i].exp);
    end
    req_valid = 1'b0; m_oimm_readdatavalid = 1'b0; m_oimm_waitrequest = 1'b0;

    // Dirty miss, no stall, then dirty miss with beat 2 stalled for 5 cycles
    run_dirty(32'h0000_2000, 32'h0000_3000, 32'hD000_0000, 99, 0);
    run_dirty(32'h0000_4000, 32'h0000_5000, 32'hC100_0000, 2, 5);

    // Reset asserted while beat 1 of a read burst is on the bus
    @(posedge clk); #1;
    req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = 32'h0000_7000;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; m_oimm_readdatavalid = 1'b1; m_oimm_readdata = 32'h70;
    @(posedge clk); #1; m_oimm_readdata = 32'h71; #1;
    check("pre_reset_beat1", {fill_we, fill_idx, fill_data}, {1'b1, 2'd1, 32'h71});
    rstnn = 1'b0; #1;
    check("reset_mid_now", {busy, fill_we, done, m_oimm_requestvalid, vic_rd_en, m_oimm_writelast, fill_data, m_oimm_address}, 70'b0);
    @(posedge clk); #1; m_oimm_readdatavalid = 1'b0; #1;
    check("reset_mid_next", {busy, fill_we, done, m_oimm_requestvalid, req_ready, fill_data, m_oimm_address}, {4'b0, 1'b1, 64'b0});
    rstnn = 1'b1;

    // Normal operation after reset; also exercises the statistics counters
    run_clean(32'h0000_800C, 32'h0000_8000, 32'h8000);
    run_clean(32'h0000_9000, 32'h0000_9000, 32'h9000);
    run_clean(32'h0000_A008, 32'h0000_A000, 32'hA000);
    run_dirty(32'h0000_B000, 32'h0000_C000, 32'hB500_0000, 0, 2);
    run_dirty(32'h0000_D000, 32'h0000_E000, 32'hE600_0000, 3, 1);
`ifdef ORCA_CACHE_REFILL_STATS_EN
    check("stats", {stat_refill_cnt, stat_wb_cnt}, {32'd5, 32'd2});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
